fb_ddram_wrbuf: RTL



---
 rtl/fb_wrbuf_pkg.sv | 25 ++
 rtl/fb_wrbuf_fifo.sv | 50 +++++
 rtl/fb_ddram_wrbuf.sv | 112 +++++++++++
 3 files changed

// File: rtl/fb_wrbuf_pkg.sv
// Shared types and constants for the frame-buffer DDRAM write buffer.
// One queued write is a packed {addr, din, be} record.
package fb_wrbuf_pkg;

   localparam int unsigned FB_AW    = 29;
   localparam logic [7:0]  FB_BURST = 8'd1;

   typedef struct packed {
      logic [FB_AW-1:0] addr;
      logic [63:0]      din;
      logic [7:0]       be;
   } fb_wr_t;

   // Newer bytes win where enabled; enables accumulate.
   function automatic fb_wr_t fb_merge(input fb_wr_t held, input fb_wr_t nw);
      fb_wr_t r;
      r = held;
      for (int unsigned i = 0; i < 8; i++) begin
         if (nw.be[i]) r.din[8*i +: 8] = nw.din[8*i +: 8];
      end
      r.be = held.be | nw.be;
      return r;
   endfunction

endpackage

// File: rtl/fb_wrbuf_fifo.sv
// Single-clock FIFO of fb_wr_t records in register storage.
// Caller guarantees push only when accepted and pop only when non-empty.
module fb_wrbuf_fifo
   import fb_wrbuf_pkg::*;
#(
   parameter int unsigned DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  fb_wr_t                   din,
   output fb_wr_t                   dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned LW = PW + 1;

   fb_wr_t         mem [DEPTH];
   logic [PW-1:0]  wr_ptr;
   logic [PW-1:0]  rd_ptr;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
      end
   end

   assign dout  = mem[rd_ptr];
   assign full  = (level == LW'(DEPTH));
   assign empty = (level == '0);

endmodule

// File: rtl/fb_ddram_wrbuf.sv
// Write buffer from the rotator pixel port to the DDRAM Avalon-MM write port.
// Define JTFRAME_FB_MERGE_EN to merge same-address writes ahead of the FIFO.
module fb_ddram_wrbuf
   import fb_wrbuf_pkg::*;
#(
   parameter int unsigned AW    = 29,
   parameter int unsigned DEPTH = 16,
   parameter int unsigned HOLD  = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_we,
   input  logic [AW-1:0]           in_addr,
   input  logic [63:0]             in_din,
   input  logic [7:0]              in_be,
   input  logic                    ovf_clr,
   input  logic                    DDRAM_BUSY,
   output logic [AW-1:0]           DDRAM_ADDR,
   output logic [63:0]             DDRAM_DIN,
   output logic [7:0]              DDRAM_BE,
   output logic                    DDRAM_WE,
   output logic [7:0]              DDRAM_BURSTCNT,
   output logic                    DDRAM_RD,
   output logic                    ovf,
   output logic [$clog2(DEPTH):0]  level
);

   logic   push_req, push, pop, drop, full, empty, fire;
   fb_wr_t in_wr, push_data, head;

   assign in_wr = '{addr: FB_AW'(in_addr), din: in_din, be: in_be};

   // A pop refills the output register: either it is idle or it completes now.
   assign fire = DDRAM_WE & ~DDRAM_BUSY;
   assign pop  = ~empty & (~DDRAM_WE | fire);
   assign push = push_req & (~full | pop);
   assign drop = push_req & full & ~pop;

`ifdef JTFRAME_FB_MERGE_EN
   logic       held_valid, same, expire;
   fb_wr_t     held;
   logic [7:0] hold_cnt;

   assign same   = held_valid & (held.addr == in_wr.addr);
   assign expire = held_valid & ~in_we & (hold_cnt == 8'(HOLD - 1));

   always_comb begin
      push_req  = 1'b0;
      push_data = held;
      if ((in_we && held_valid && !same) || expire) push_req = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         held_valid <= 1'b0;
         held       <= '0;
         hold_cnt   <= '0;
      end else if (in_we) begin
         held       <= same ? fb_merge(held, in_wr) : in_wr;
         held_valid <= 1'b1;
         hold_cnt   <= '0;
      end else if (expire) begin
         held_valid <= 1'b0;
         hold_cnt   <= '0;
      end else if (held_valid) begin
         hold_cnt   <= hold_cnt + 8'd1;
      end
   end
`else
   assign push_req  = in_we;
   assign push_data = in_wr;
`endif

   fb_wrbuf_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (push_data),
      .dout  (head),
      .full  (full),
      .empty (empty),
      .level (level)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         DDRAM_WE   <= 1'b0;
         DDRAM_ADDR <= '0;
         DDRAM_DIN  <= '0;
         DDRAM_BE   <= '0;
      end else if (pop) begin
         DDRAM_WE   <= 1'b1;
         DDRAM_ADDR <= AW'(head.addr);
         DDRAM_DIN  <= head.din;
         DDRAM_BE   <= head.be;
      end else if (fire) begin
         DDRAM_WE   <= 1'b0;
      end
   end

   // A drop on the same edge as a clear leaves the flag set.
   always_ff @(posedge clk) begin
      if (rst)          ovf <= 1'b0;
      else if (drop)    ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
   end

   assign DDRAM_BURSTCNT = FB_BURST;
   assign DDRAM_RD       = 1'b0;

endmodule
